// File: rtl/bsg_nasti_write_arbiter.sv
// bsg_nasti_write_arbiter
//   Shares one NASTI write port (AW/W/B) among num_clients_p memory clients.
//   AW: round-robin arbitration, client index spliced into the outgoing ID
//       between the payload and the client ID ({payload, client, id}).
//   W : beats follow AW grant order via a small FIFO of granted client indices.
//   B : routed back to the client named by the ID client field; out-of-range
//       client fields are accepted and dropped.
//   Optional build macro BSG_NASTI_WARB_FIXED_PRIO_EN: fixed priority
//   (lowest valid index wins) instead of round-robin.
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   c_aw_v_i/c_aw_data_i/c_aw_ready_o  per-client AW, data {payload,id}
//   c_w_v_i/c_w_data_i/c_w_ready_o     per-client W, data {payload,last}
//   c_b_v_o/c_b_data_o/c_b_ready_i     per-client B valid, broadcast data
//   m_aw_*, m_w_*, m_b_*               shared master-side channels

// Small FIFO of granted client indices.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full_o or pop when empty_o.
module bsg_nasti_warb_fifo #(
   parameter int width_p = 3,
   parameter int els_p   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push_v_i,
   input  logic [width_p-1:0] push_data_i,
   input  logic               pop_i,
   output logic               full_o,
   output logic               empty_o,
   output logic [width_p-1:0] head_o
);
   localparam int pw_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cw_lp = $clog2(els_p + 1);

   logic [width_p-1:0] mem_r [els_p];
   logic [pw_lp-1:0]   wptr_r, rptr_r;
   logic [cw_lp-1:0]   count_r;

   assign full_o  = (count_r == cw_lp'(els_p));
   assign empty_o = (count_r == '0);
   assign head_o  = mem_r[rptr_r];

   always_ff @(posedge clk) begin
      if (push_v_i) mem_r[wptr_r] <= push_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_v_i)
            wptr_r <= (wptr_r == pw_lp'(els_p - 1)) ? '0 : wptr_r + pw_lp'(1);
         if (pop_i)
            rptr_r <= (rptr_r == pw_lp'(els_p - 1)) ? '0 : rptr_r + pw_lp'(1);
         if (push_v_i && !pop_i)
            count_r <= count_r + cw_lp'(1);
         else if (!push_v_i && pop_i)
            count_r <= count_r - cw_lp'(1);
      end
   end
endmodule

// Write-port arbiter: AW round-robin (or fixed priority), W in grant order, B routed by ID.
// Latency: AW/W/B forwarding is combinational; W of a burst starts >=1 cycle after its AW.
// Backpressure: AW stalls when the pending-burst FIFO is full; ready follows master ready.
module bsg_nasti_write_arbiter #(
   parameter int num_clients_p = 5,
   parameter int id_width_p    = 5,
   parameter int aw_width_p    = 64,
   parameter int w_width_p     = 65,
   parameter int b_width_p     = 2,
   parameter int wfifo_els_p   = 4,
   localparam int lg_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [num_clients_p-1:0]                            c_aw_v_i,
   input  logic [num_clients_p*(aw_width_p+id_width_p)-1:0]    c_aw_data_i,
   output logic [num_clients_p-1:0]                            c_aw_ready_o,
   input  logic [num_clients_p-1:0]                            c_w_v_i,
   input  logic [num_clients_p*w_width_p-1:0]                  c_w_data_i,
   output logic [num_clients_p-1:0]                            c_w_ready_o,
   output logic [num_clients_p-1:0]                            c_b_v_o,
   output logic [b_width_p+id_width_p-1:0]                     c_b_data_o,
   input  logic [num_clients_p-1:0]                            c_b_ready_i,
   output logic                                                m_aw_v_o,
   output logic [aw_width_p+lg_lp+id_width_p-1:0]              m_aw_data_o,
   input  logic                                                m_aw_ready_i,
   output logic                                                m_w_v_o,
   output logic [w_width_p-1:0]                                m_w_data_o,
   input  logic                                                m_w_ready_i,
   input  logic                                                m_b_v_i,
   input  logic [b_width_p+lg_lp+id_width_p-1:0]               m_b_data_i,
   output logic                                                m_b_ready_o
);
   localparam int aw_cw_lp = aw_width_p + id_width_p;
   localparam logic [lg_lp:0] num_clients_lp = (lg_lp + 1)'(num_clients_p);

   // ---------------- AW arbitration ----------------
   logic                 lock_r;
   logic [lg_lp-1:0]     lock_client_r;
   logic [lg_lp-1:0]     arb_grant;
   logic [lg_lp-1:0]     grant;
   logic [aw_cw_lp-1:0]  aw_word;
   logic                 aw_hs;
   logic                 fifo_full, fifo_empty, fifo_pop;
   logic [lg_lp-1:0]     fifo_head;

`ifdef BSG_NASTI_WARB_FIXED_PRIO_EN
   always_comb begin
      arb_grant = '0;
      // Scan downward so the lowest valid index is the last (winning) write.
      for (int i = num_clients_p - 1; i >= 0; i--) begin
         if (c_aw_v_i[lg_lp'(i)]) arb_grant = lg_lp'(i);
      end
   end
`else
   logic [lg_lp-1:0] last_grant_r;
   logic             rr_found;
   int               rr_idx;

   always_comb begin
      arb_grant = '0;
      rr_found  = 1'b0;
      rr_idx    = 0;
      // Start just after the previous winner; one subtraction wraps since
      // last_grant_r + 1 + i never reaches 2*num_clients_p.
      for (int i = 0; i < num_clients_p; i++) begin
         rr_idx = int'(last_grant_r) + 1 + i;
         if (rr_idx >= num_clients_p) rr_idx = rr_idx - num_clients_p;
         if (!rr_found && c_aw_v_i[lg_lp'(rr_idx)]) begin
            rr_found  = 1'b1;
            arb_grant = lg_lp'(rr_idx);
         end
      end
   end
`endif

   // Once offered and stalled, the grant is frozen so the master sees a stable word.
   assign grant    = lock_r ? lock_client_r : arb_grant;
   assign aw_word  = c_aw_data_i[grant*aw_cw_lp +: aw_cw_lp];
   assign m_aw_v_o = (lock_r | (|c_aw_v_i)) & ~fifo_full;
   assign aw_hs    = m_aw_v_o & m_aw_ready_i;
   assign m_aw_data_o = {aw_word[aw_cw_lp-1:id_width_p], grant, aw_word[id_width_p-1:0]};

   always_comb begin
      c_aw_ready_o = '0;
      if (aw_hs) c_aw_ready_o[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_r        <= 1'b0;
         lock_client_r <= '0;
`ifndef BSG_NASTI_WARB_FIXED_PRIO_EN
         last_grant_r  <= lg_lp'(num_clients_p - 1);
`endif
      end else if (aw_hs) begin
         lock_r        <= 1'b0;
`ifndef BSG_NASTI_WARB_FIXED_PRIO_EN
         last_grant_r  <= grant;
`endif
      end else if (m_aw_v_o) begin
         lock_r        <= 1'b1;
         lock_client_r <= grant;
      end
   end

   // ---------------- W forwarding ----------------
   logic [lg_lp-1:0]     w_head;
   logic [w_width_p-1:0] w_word;

   bsg_nasti_warb_fifo #(
      .width_p (lg_lp),
      .els_p   (wfifo_els_p)
   ) pending_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_v_i    (aw_hs),
      .push_data_i (grant),
      .pop_i       (fifo_pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (fifo_head)
   );

   // Steer to client 0 when empty so an unwritten slot never drives the muxes.
   assign w_head     = fifo_empty ? '0 : fifo_head;
   assign w_word     = c_w_data_i[w_head*w_width_p +: w_width_p];
   assign m_w_v_o    = ~fifo_empty & c_w_v_i[w_head];
   assign m_w_data_o = w_word;
   assign fifo_pop   = m_w_v_o & m_w_ready_i & w_word[0];

   always_comb begin
      c_w_ready_o = '0;
      c_w_ready_o[w_head] = ~fifo_empty & m_w_ready_i;
   end

   // ---------------- B routing ----------------
   logic [lg_lp-1:0] b_client;
   logic             b_client_ok;

   assign b_client    = m_b_data_i[id_width_p +: lg_lp];
   assign b_client_ok = ({1'b0, b_client} < num_clients_lp);
   assign c_b_data_o  = {m_b_data_i[id_width_p+lg_lp +: b_width_p], m_b_data_i[id_width_p-1:0]};
   // Responses for nonexistent clients are swallowed so the master never hangs.
   assign m_b_ready_o = b_client_ok ? c_b_ready_i[b_client] : 1'b1;

   always_comb begin
      c_b_v_o = '0;
      for (int k = 0; k < num_clients_p; k++) begin
         c_b_v_o[k] = m_b_v_i & (b_client == lg_lp'(k));
      end
   end
endmodule

// File: tb/tb_bsg_nasti_write_arbiter.sv
// Directed bench for bsg_nasti_write_arbiter at default parameters.
// Inputs change at the falling edge; outputs are checked 1 ns later.
module tb_bsg_nasti_write_arbiter;
   localparam int N   = 5;
   localparam int IDW = 5;
   localparam int AWW = 64;
   localparam int WW  = 65;
   localparam int BW  = 2;
   localparam int LG  = 3;
   localparam int CW  = AWW + IDW;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N-1:0]         c_aw_v_i;
   logic [N*CW-1:0]      c_aw_data_i;
   logic [N-1:0]         c_aw_ready_o;
   logic [N-1:0]         c_w_v_i;
   logic [N*WW-1:0]      c_w_data_i;
   logic [N-1:0]         c_w_ready_o;
   logic [N-1:0]         c_b_v_o;
   logic [BW+IDW-1:0]    c_b_data_o;
   logic [N-1:0]         c_b_ready_i;
   logic                 m_aw_v_o;
   logic [AWW+LG+IDW-1:0] m_aw_data_o;
   logic                 m_aw_ready_i;
   logic                 m_w_v_o;
   logic [WW-1:0]        m_w_data_o;
   logic                 m_w_ready_i;
   logic                 m_b_v_i;
   logic [BW+LG+IDW-1:0] m_b_data_i;
   logic                 m_b_ready_o;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   bsg_nasti_write_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .c_aw_v_i     (c_aw_v_i),
      .c_aw_data_i  (c_aw_data_i),
      .c_aw_ready_o (c_aw_ready_o),
      .c_w_v_i      (c_w_v_i),
      .c_w_data_i   (c_w_data_i),
      .c_w_ready_o  (c_w_ready_o),
      .c_b_v_o      (c_b_v_o),
      .c_b_data_o   (c_b_data_o),
      .c_b_ready_i  (c_b_ready_i),
      .m_aw_v_o     (m_aw_v_o),
      .m_aw_data_o  (m_aw_data_o),
      .m_aw_ready_i (m_aw_ready_i),
      .m_w_v_o      (m_w_v_o),
      .m_w_data_o   (m_w_data_o),
      .m_w_ready_i  (m_w_ready_i),
      .m_b_v_i      (m_b_v_i),
      .m_b_data_i   (m_b_data_i),
      .m_b_ready_o  (m_b_ready_o)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_aw(input int k, input logic [63:0] p, input logic [4:0] id);
      c_aw_data_i[k*CW +: CW] = {p, id};
   endtask

   task automatic set_w(input int k, input logic [63:0] p, input logic last);
      c_w_data_i[k*WW +: WW] = {p, last};
   endtask

   function automatic logic [71:0] aw_exp(input logic [63:0] p, input int c, input logic [4:0] id);
      return {p, 3'(c), id};
   endfunction

`ifdef BSG_NASTI_WARB_FIXED_PRIO_EN
   int exp_g [6] = '{0, 0, 0, 0, 0, 0};
`else
   int exp_g [6] = '{0, 1, 2, 0, 1, 2};
`endif

   initial begin
      reset = 1'b1;
      c_aw_v_i = '0; c_aw_data_i = '0; c_w_v_i = '0; c_w_data_i = '0;
      c_b_ready_i = '0; m_aw_ready_i = 1'b0; m_w_ready_i = 1'b0;
      m_b_v_i = 1'b0; m_b_data_i = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_m_aw_v", m_aw_v_o, 0);
      check("rst_m_w_v", m_w_v_o, 0);
      check("rst_c_aw_rdy", c_aw_ready_o, 0);
      check("rst_c_w_rdy", c_w_ready_o, 0);
      check("rst_c_b_v", c_b_v_o, 0);
      check("rst_m_b_rdy", m_b_ready_o, 0);
      @(negedge clk);
      reset = 1'b0;

      // Single client 3 burst of 4 beats
      @(negedge clk);
      m_aw_ready_i = 1'b1; m_w_ready_i = 1'b1;
      set_aw(3, 64'hA3A3, 5'h05); c_aw_v_i = 5'b01000;
      set_w(3, 64'hB0, 1'b0);     c_w_v_i  = 5'b01000;
      #1;
      check("t1_aw_v", m_aw_v_o, 1);
      check("t1_aw_data", m_aw_data_o, aw_exp(64'hA3A3, 3, 5'h05));
      check("t1_aw_rdy", c_aw_ready_o, 5'b01000);
      check("t1_w_same_cycle", m_w_v_o, 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         c_aw_v_i = '0;
         set_w(3, 64'hB0 + 64'(i), (i == 4));
         #1;
         check("t1_w_v", m_w_v_o, 1);
         check("t1_w_data", m_w_data_o, {64'hB0 + 64'(i), (i == 4)});
         check("t1_w_rdy", c_w_ready_o, 5'b01000);
      end
      @(negedge clk);
      #1;
      check("t1_empty_w_v", m_w_v_o, 0);
      check("t1_empty_w_rdy", c_w_ready_o, 0);

      // Three clients contend, master always ready
      for (int k = 0; k < 3; k++) begin
         set_aw(k, 64'hC0 + 64'(k), 5'(k + 8));
         set_w(k, 64'h0, 1'b1);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         c_aw_v_i = 5'b00111; c_w_v_i = 5'b00111;
         #1;
         check("t2_aw_rdy", c_aw_ready_o, 5'(1 << exp_g[i]));
         check("t2_aw_data", m_aw_data_o, aw_exp(64'hC0 + 64'(exp_g[i]), exp_g[i], 5'(exp_g[i] + 8)));
      end
      @(negedge clk);
      c_aw_v_i = '0;
      repeat (3) @(negedge clk);
      c_w_v_i = '0;

      // Stalled master: grant locked on client 1
      @(negedge clk);
      m_aw_ready_i = 1'b0;
      set_aw(1, 64'hD1, 5'h11); set_aw(0, 64'hD0, 5'h10);
      c_aw_v_i = 5'b00010;
      #1;
      check("t3_aw_v", m_aw_v_o, 1);
      check("t3_aw_data0", m_aw_data_o, aw_exp(64'hD1, 1, 5'h11));
      check("t3_aw_rdy_stall", c_aw_ready_o, 0);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         if (i == 2) c_aw_v_i = 5'b00011;
         #1;
         check("t3_aw_data_held", m_aw_data_o, aw_exp(64'hD1, 1, 5'h11));
      end
      @(negedge clk);
      m_aw_ready_i = 1'b1;
      #1;
      check("t3_hs_rdy", c_aw_ready_o, 5'b00010);
      check("t3_hs_data", m_aw_data_o, aw_exp(64'hD1, 1, 5'h11));
      @(negedge clk);
      c_aw_v_i = 5'b00001;
      #1;
      check("t3_next_rdy", c_aw_ready_o, 5'b00001);
      check("t3_next_data", m_aw_data_o, aw_exp(64'hD0, 0, 5'h10));
      @(negedge clk);
      c_aw_v_i = '0; c_w_v_i = 5'b00011;
      repeat (3) @(negedge clk);
      c_w_v_i = '0;

      // Pending-burst FIFO fills with W held off
      set_aw(2, 64'hE2, 5'h02); set_w(2, 64'hF2, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         c_aw_v_i = 5'b00100;
         #1;
         check("t4_fill_rdy", c_aw_ready_o, 5'b00100);
      end
      @(negedge clk);
      #1;
      check("t4_full_aw_v", m_aw_v_o, 0);
      check("t4_full_aw_rdy", c_aw_ready_o, 0);
      @(negedge clk);
      c_w_v_i = 5'b00100;
      #1;
      check("t4_pop_aw_blocked", m_aw_v_o, 0);
      check("t4_pop_w_v", m_w_v_o, 1);
      check("t4_pop_w_rdy", c_w_ready_o, 5'b00100);
      @(negedge clk);
      c_w_v_i = '0;
      #1;
      check("t4_after_pop_aw_v", m_aw_v_o, 1);
      check("t4_after_pop_rdy", c_aw_ready_o, 5'b00100);

      // Reset in the middle of a burst
      @(negedge clk);
      c_aw_v_i = '0;
      set_w(2, 64'hF3, 1'b0); c_w_v_i = 5'b00100;
      #1;
      check("t5_mid_w_v", m_w_v_o, 1);
      check("t5_mid_w_data", m_w_data_o, {64'hF3, 1'b0});
      @(negedge clk);
      reset = 1'b1; c_w_v_i = '0; m_w_ready_i = 1'b0; m_aw_ready_i = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      set_aw(4, 64'h44, 5'h04);
      c_w_v_i = 5'b00100; m_w_ready_i = 1'b1;
      c_aw_v_i = 5'b11111; m_aw_ready_i = 1'b1;
      #1;
      check("t5_post_w_v", m_w_v_o, 0);
      check("t5_post_w_rdy", c_w_ready_o, 0);
      check("t5_post_aw_rdy", c_aw_ready_o, 5'b00001);
      check("t5_post_aw_data", m_aw_data_o, aw_exp(64'hD0, 0, 5'h10));
      @(negedge clk);
      c_aw_v_i = '0; c_w_v_i = '0;

      // B routing
      @(negedge clk);
      m_b_v_i = 1'b1; m_b_data_i = {2'b10, 3'd4, 5'h1A}; c_b_ready_i = '0;
      #1;
      check("b4_v", c_b_v_o, 5'b10000);
      check("b4_rdy_low", m_b_ready_o, 0);
      check("b4_data", c_b_data_o, 7'h5A);
      @(negedge clk);
      c_b_ready_i = 5'b10000;
      #1;
      check("b4_rdy_high", m_b_ready_o, 1);
      @(negedge clk);
      c_b_ready_i = 5'b01111;
      #1;
      check("b4_rdy_other", m_b_ready_o, 0);
      @(negedge clk);
      m_b_data_i = {2'b01, 3'd6, 5'h03}; c_b_ready_i = '0;
      #1;
      check("b6_v", c_b_v_o, 0);
      check("b6_rdy", m_b_ready_o, 1);
      @(negedge clk);
      m_b_data_i = {2'b11, 3'd0, 5'h07}; c_b_ready_i = 5'b00001;
      #1;
      check("b0_v", c_b_v_o, 5'b00001);
      check("b0_rdy", m_b_ready_o, 1);
      check("b0_data", c_b_data_o, 7'h67);
      @(negedge clk);
      m_b_v_i = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
